// File: rtl/ring_phase_monitor_if.sv
// Sample/status bundle between a one-hot ring counter consumer and its monitor.
// The master drives the samples and the clear; the slave reports phase and fault status.
interface ring_phase_monitor_if #(
  parameter int N     = 4,
  parameter int REV_W = 8
);
  logic                 en;
  logic [N-1:0]         ring_in;
  logic                 clr_err;
  logic [$clog2(N)-1:0] phase_idx;
  logic                 phase_valid;
  logic [REV_W-1:0]     rev_count;
  logic                 wrap_pulse;
  logic                 locked;
  logic                 err_zero;
  logic                 err_multi;
  logic                 err_seq;
  logic                 reseed_req;

  modport master (
    output en, ring_in, clr_err,
    input  phase_idx, phase_valid, rev_count, wrap_pulse, locked,
           err_zero, err_multi, err_seq, reseed_req
  );

  modport slave (
    input  en, ring_in, clr_err,
    output phase_idx, phase_valid, rev_count, wrap_pulse, locked,
           err_zero, err_multi, err_seq, reseed_req
  );
endinterface

// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring counter for legal left rotation, decodes the active phase,
// counts revolutions and latches a sticky fault that requests a reseed.
module ring_phase_monitor #(
  parameter int N        = 4,
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic               clk,
  input  logic               rst,
  ring_phase_monitor_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int SW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED, FAULT} state_t;

  state_t        state;
  logic [SW-1:0] sync_cnt;
  logic [N-1:0]  prev;

  logic [N-1:0]  sample;
  logic          is_zero;
  logic          is_multi;
  logic          is_rot;

  function automatic int ones(input logic [N-1:0] v);
    ones = 0;
    for (int i = 0; i < N; i++) ones += int'(v[i]);
  endfunction

  function automatic logic [IW-1:0] onehot_idx(input logic [N-1:0] v);
    onehot_idx = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) onehot_idx = IW'(i);
  endfunction

  function automatic logic [N-1:0] rot(input logic [N-1:0] v);
    rot = {v[N-2:0], v[N-1]};
  endfunction

  always_comb begin
    sample   = bus.ring_in;
    is_zero  = (sample == '0);
    is_multi = (ones(sample) > 1);
    is_rot   = (sample == rot(prev));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= SEARCH;
      sync_cnt        <= '0;
      prev            <= '0;
      bus.phase_idx   <= '0;
      bus.phase_valid <= 1'b0;
      bus.rev_count   <= '0;
      bus.wrap_pulse  <= 1'b0;
      bus.locked      <= 1'b0;
      bus.err_zero    <= 1'b0;
      bus.err_multi   <= 1'b0;
      bus.err_seq     <= 1'b0;
      bus.reseed_req  <= 1'b0;
    end else begin
      bus.wrap_pulse <= 1'b0;
      if (bus.clr_err) begin
        // Restart the search; phase_idx deliberately keeps its last value
        state           <= SEARCH;
        sync_cnt        <= '0;
        bus.rev_count   <= '0;
        bus.phase_valid <= 1'b0;
        bus.locked      <= 1'b0;
        bus.err_zero    <= 1'b0;
        bus.err_multi   <= 1'b0;
        bus.err_seq     <= 1'b0;
        bus.reseed_req  <= 1'b0;
      end else if (bus.en && state != FAULT) begin
        if (is_zero || is_multi) begin
          state           <= FAULT;
          bus.reseed_req  <= 1'b1;
          bus.locked      <= 1'b0;
          bus.phase_valid <= 1'b0;
          bus.err_zero    <= is_zero;
          bus.err_multi   <= is_multi;
        end else begin
          case (state)
            SEARCH: begin
              state    <= SYNC;
              sync_cnt <= '0;
              prev     <= sample;
            end
            SYNC: begin
              prev <= sample;
              if (!is_rot) begin
                sync_cnt <= '0;
              end else begin
                sync_cnt <= sync_cnt + 1'b1;
                if ((sync_cnt + 1'b1) == SW'(LOCK_CNT)) begin
                  state           <= LOCKED;
                  bus.locked      <= 1'b1;
                  bus.phase_idx   <= onehot_idx(sample);
                  bus.phase_valid <= 1'b1;
                end
              end
            end
            LOCKED: begin
              if (is_rot) begin
                prev            <= sample;
                bus.phase_idx   <= onehot_idx(sample);
                bus.phase_valid <= 1'b1;
                if (sample[0] && prev[N-1]) begin
                  bus.wrap_pulse <= 1'b1;
                  bus.rev_count  <= bus.rev_count + 1'b1;
                end
              end else begin
                state           <= FAULT;
                bus.reseed_req  <= 1'b1;
                bus.locked      <= 1'b0;
                bus.phase_valid <= 1'b0;
                bus.err_seq     <= 1'b1;
              end
            end
            default: state <= FAULT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed scoreboard bench for ring_phase_monitor (N=4, REV_W=8, LOCK_CNT=2).
module tb_ring_phase_monitor;

  logic clk;
  logic rst;
  int   ntests;
  int   nfail;

  ring_phase_monitor_if #(.N(4), .REV_W(8)) bus ();

  ring_phase_monitor #(.N(4), .REV_W(8), .LOCK_CNT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] sb_q[$];
  string       tag_q[$];

  // Packed view: {reseed, err_seq, err_multi, err_zero, locked, wrap, rev[7:0], valid, idx[1:0]}
  function automatic logic [16:0] mk(input logic [1:0] idx, input logic v, input logic [7:0] rev,
                                     input logic w, input logic l, input logic ez,
                                     input logic em, input logic es, input logic rs);
    mk = {rs, es, em, ez, l, w, rev, v, idx};
  endfunction

  function automatic logic [16:0] observed();
    observed = {bus.reseed_req, bus.err_seq, bus.err_multi, bus.err_zero, bus.locked,
                bus.wrap_pulse, bus.rev_count, bus.phase_valid, bus.phase_idx};
  endfunction

  task automatic check_now(input logic [16:0] expv, input string tag);
    logic [16:0] obs;
    obs = observed();
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] r, input logic c,
                      input logic [16:0] expv, input string tag);
    logic [16:0] want;
    string       t;
    bus.en      = e;
    bus.ring_in = r;
    bus.clr_err = c;
    sb_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    t    = tag_q.pop_front();
    check_now(want, t);
  endtask

  initial begin
    ntests      = 0;
    nfail       = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.ring_in = 4'b0000;
    bus.clr_err = 1'b0;
    @(posedge clk);
    #1;
    check_now(17'h0, "reset_state");
    rst = 1'b0;

    // Ring stuck at zero
    step(1, 4'b0000, 0, mk(0,0,0,0,0,1,0,0,1), "zero_fault");
    step(1, 4'b0001, 0, mk(0,0,0,0,0,1,0,0,1), "fault_ignores_sample");
    step(1, 4'b0001, 1, mk(0,0,0,0,0,0,0,0,0), "clr_from_zero");

    // Lock and one revolution
    step(1, 4'b0001, 0, mk(0,0,0,0,0,0,0,0,0), "sync_first");
    step(1, 4'b0010, 0, mk(0,0,0,0,0,0,0,0,0), "sync_second");
    step(1, 4'b0100, 0, mk(2,1,0,0,1,0,0,0,0), "lock_idx2");
    step(1, 4'b1000, 0, mk(3,1,0,0,1,0,0,0,0), "locked_idx3");
    step(1, 4'b0001, 0, mk(0,1,1,1,1,0,0,0,0), "wrap_rev1");
    step(1, 4'b0010, 0, mk(1,1,1,0,1,0,0,0,0), "after_wrap");

    // Enable toggling holds outputs
    step(0, 4'b0100, 0, mk(1,1,1,0,1,0,0,0,0), "hold_en0_a");
    step(1, 4'b0100, 0, mk(2,1,1,0,1,0,0,0,0), "resume_idx2");
    step(0, 4'b1000, 0, mk(2,1,1,0,1,0,0,0,0), "hold_en0_b");
    step(1, 4'b1000, 0, mk(3,1,1,0,1,0,0,0,0), "resume_idx3");
    step(1, 4'b0001, 0, mk(0,1,2,1,1,0,0,0,0), "wrap_rev2");
    step(0, 4'b0010, 0, mk(0,1,2,0,1,0,0,0,0), "hold_kills_pulse");

    // Skipped phase while locked
    step(1, 4'b0010, 0, mk(1,1,2,0,1,0,0,0,0), "locked_idx1");
    step(1, 4'b1000, 0, mk(1,0,2,0,0,0,0,1,1), "err_seq_skip");
    step(1, 4'b0001, 1, mk(1,0,0,0,0,0,0,0,0), "clr_from_seq");

    // Multiple bits set from SEARCH
    step(1, 4'b0011, 0, mk(1,0,0,0,0,0,1,0,1), "err_multi");
    step(1, 4'b0011, 1, mk(1,0,0,0,0,0,0,0,0), "clr_from_multi");

    // Lock across the wrap point: no pulse while still syncing
    step(1, 4'b0100, 0, mk(1,0,0,0,0,0,0,0,0), "resync_a");
    step(1, 4'b1000, 0, mk(1,0,0,0,0,0,0,0,0), "resync_b");
    step(1, 4'b0001, 0, mk(0,1,0,0,1,0,0,0,0), "lock_at_wrap_no_pulse");
    step(1, 4'b0001, 0, mk(0,0,0,0,0,0,0,1,1), "err_seq_hold");
    step(1, 4'b0000, 1, mk(0,0,0,0,0,0,0,0,0), "clr_again");

    // Illegal step during SYNC restarts the lock count
    step(1, 4'b0001, 0, mk(0,0,0,0,0,0,0,0,0), "sync_restart_a");
    step(1, 4'b0100, 0, mk(0,0,0,0,0,0,0,0,0), "sync_bad_step");
    step(1, 4'b1000, 0, mk(0,0,0,0,0,0,0,0,0), "sync_count_reset");
    step(1, 4'b0001, 0, mk(0,1,0,0,1,0,0,0,0), "lock_after_restart");
    step(1, 4'b0010, 0, mk(1,1,0,0,1,0,0,0,0), "locked_idx1_b");

    // Asynchronous reset between clock edges
    bus.en      = 1'b1;
    bus.ring_in = 4'b0100;
    #2;
    rst = 1'b1;
    #1;
    check_now(17'h0, "async_rst");
    @(posedge clk);
    #1;
    check_now(17'h0, "rst_held");
    rst = 1'b0;
    step(1, 4'b0100, 0, mk(0,0,0,0,0,0,0,0,0), "post_rst_sync");
    step(1, 4'b0000, 0, mk(0,0,0,0,0,1,0,0,1), "post_rst_zero_fault");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
